// File: rtl/stack_arbiter_if.sv
// Request-side bus for stack_arbiter: two requester ports, each with a
// push/pop request, push data, and a completion ack/err/pop-data return.
// master = requester side, slave = arbiter side.
interface stack_arbiter_if;
   logic       req0_push;
   logic       req0_pop;
   logic [7:0] req0_din;
   logic       req0_ack;
   logic       req0_err;
   logic [7:0] req0_dout;

   logic       req1_push;
   logic       req1_pop;
   logic [7:0] req1_din;
   logic       req1_ack;
   logic       req1_err;
   logic [7:0] req1_dout;

   modport master (
      output req0_push, req0_pop, req0_din,
      input  req0_ack, req0_err, req0_dout,
      output req1_push, req1_pop, req1_din,
      input  req1_ack, req1_err, req1_dout
   );

   modport slave (
      input  req0_push, req0_pop, req0_din,
      output req0_ack, req0_err, req0_dout,
      input  req1_push, req1_pop, req1_din,
      output req1_ack, req1_err, req1_dout
   );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: arbitrates two requesters onto one external stack RAM.
// One transaction at a time: IDLE -> ISSUE -> CAPTURE -> DONE for a valid
// push/pop, IDLE -> DONE with err for an invalid one. All outputs registered.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// between simultaneous requests; otherwise port 0 has fixed priority.
module stack_arbiter (
   input  logic           clk,
   input  logic           reset,
   stack_arbiter_if.slave bus,
   output logic [7:0]     stk_din,
   output logic           stk_we,
   output logic           stk_oe,
   output logic           stk_rst,
   input  logic [7:0]     stk_dout,
   output logic [8:0]     count,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

   localparam logic [8:0] DEPTH = 9'd256;

   state_t     state, state_next;
   logic       grant, grant_next;      // 0 = port 0, 1 = port 1
   logic       op_push, op_push_next;  // 1 = push, 0 = pop
   logic       last, last_next;        // port served by the last completed transaction
   logic [7:0] stk_din_next;
   logic       stk_we_next, stk_oe_next;
   logic [8:0] count_next;
   logic       ack0_next, ack1_next, err0_next, err1_next;
   logic [7:0] dout0_next, dout1_next;

   logic       pend0, pend1, sel, sel_push, sel_pop, sel_bad;
   logic [7:0] sel_din;

   // Pick the port to serve and classify its request as valid or invalid.
   always_comb begin
      pend0 = bus.req0_push | bus.req0_pop;
      pend1 = bus.req1_push | bus.req1_pop;
`ifdef ARB_ROUND_ROBIN_EN
      if (pend0 && pend1) sel = ~last;
      else                sel = pend1 & ~pend0;
`else
      sel = pend1 & ~pend0;
`endif
      sel_push = sel ? bus.req1_push : bus.req0_push;
      sel_pop  = sel ? bus.req1_pop  : bus.req0_pop;
      sel_din  = sel ? bus.req1_din  : bus.req0_din;
      sel_bad  = (sel_push && sel_pop) ||
                 (sel_push && count == DEPTH) ||
                 (sel_pop  && count == 9'd0);
   end

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_next   = state;
      grant_next   = grant;
      op_push_next = op_push;
      last_next    = last;
      stk_din_next = stk_din;
      stk_we_next  = 1'b0;
      stk_oe_next  = 1'b0;
      count_next   = count;
      ack0_next    = 1'b0;
      ack1_next    = 1'b0;
      err0_next    = bus.req0_err;
      err1_next    = bus.req1_err;
      dout0_next   = bus.req0_dout;
      dout1_next   = bus.req1_dout;

      case (state)
         IDLE: begin
            if (pend0 || pend1) begin
               grant_next   = sel;
               op_push_next = sel_push;
               if (sel_bad) begin
                  // Invalid op: no strobe, count untouched, ack with err next cycle.
                  state_next = DONE;
                  if (sel) begin ack1_next = 1'b1; err1_next = 1'b1; end
                  else     begin ack0_next = 1'b1; err0_next = 1'b1; end
               end else begin
                  state_next  = ISSUE;
                  stk_we_next = sel_push;
                  stk_oe_next = ~sel_push;
                  if (sel_push) stk_din_next = sel_din;
               end
            end
         end
         ISSUE: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            // RAM pop data is registered off the ISSUE strobe, so it is valid now.
            state_next = DONE;
            if (op_push) count_next = count + 9'd1;
            else         count_next = count - 9'd1;
            if (grant) begin
               ack1_next = 1'b1;
               err1_next = 1'b0;
               if (!op_push) dout1_next = stk_dout;
            end else begin
               ack0_next = 1'b1;
               err0_next = 1'b0;
               if (!op_push) dout0_next = stk_dout;
            end
         end
         DONE: begin
            state_next = IDLE;
            last_next  = grant;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Registered datapath and outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant         <= 1'b0;
         op_push       <= 1'b0;
         last          <= 1'b1;   // port 0 wins the first tie after reset
         stk_din       <= 8'h00;
         stk_we        <= 1'b0;
         stk_oe        <= 1'b0;
         stk_rst       <= 1'b1;   // held through the first clock after release
         count         <= 9'd0;
         busy          <= 1'b0;
         bus.req0_ack  <= 1'b0;
         bus.req0_err  <= 1'b0;
         bus.req0_dout <= 8'h00;
         bus.req1_ack  <= 1'b0;
         bus.req1_err  <= 1'b0;
         bus.req1_dout <= 8'h00;
      end else begin
         grant         <= grant_next;
         op_push       <= op_push_next;
         last          <= last_next;
         stk_din       <= stk_din_next;
         stk_we        <= stk_we_next;
         stk_oe        <= stk_oe_next;
         stk_rst       <= 1'b0;
         count         <= count_next;
         busy          <= (state_next != IDLE);
         bus.req0_ack  <= ack0_next;
         bus.req0_err  <= err0_next;
         bus.req0_dout <= dout0_next;
         bus.req1_ack  <= ack1_next;
         bus.req1_err  <= err1_next;
         bus.req1_dout <= dout1_next;
      end
   end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 req0_push, req0_pop  input  1 each  port-0 push/pop request, held until req0_ack.
REQ-005 req0_din  input  8  port-0 push data, stable while req0_push high.
REQ-006 req0_ack  output  1  port-0 one-cycle completion pulse.
REQ-007 req0_err  output  1  port-0 error flag, valid with req0_ack.
REQ-008 req0_dout  output  8  port-0 pop data, valid with req0_ack, held until next port-0 ack.
REQ-009 req1_push, req1_pop, req1_din, req1_ack, req1_err, req1_dout: SHALL be identical to the port-0 signals, for port 1.
REQ-010 stk_din  output  8  write data to stack RAM.
REQ-011 stk_we  output  1  stack push strobe.
REQ-012 stk_oe  output  1  stack pop strobe.
REQ-013 stk_rst  output  1  synchronous reset to stack RAM.
REQ-014 stk_dout  input  8  stack RAM registered pop data.
REQ-015 count  output  9  stack occupancy, 0..256.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE; all outputs SHALL be registered.
REQ-018 IDLE: with no request pending, the FSM SHALL stay in IDLE; with a request pending, it SHALL register the grant and operation, then go to ISSUE (valid op) or DONE with err=1 (invalid op).
REQ-019 Invalid op: push with count=256, pop with count=0, or push and pop both high on the granted port; no stack strobe SHALL be issued and count SHALL be unchanged.
REQ-020 ISSUE: stk_we (push, with stk_din = granted din) or stk_oe (pop) SHALL be high for exactly this one cycle; the next state SHALL be CAPTURE.
REQ-021 CAPTURE: for a pop, the block SHALL latch stk_dout into the granted reqN_dout; count SHALL be incremented (push) or decremented (pop); the next state SHALL be DONE.
REQ-022 DONE: the granted reqN_ack SHALL be high for one cycle (err as determined); the next state SHALL be IDLE.
REQ-023 Latency: a valid op SHALL give ack 3 cycles after the IDLE sampling edge; an invalid op SHALL give ack 1 cycle after it.
REQ-024 A requester SHALL deassert its request in the cycle after ack; requests arriving while busy SHALL wait.
REQ-025 stk_we and stk_oe SHALL never be high together; at most one transaction SHALL be in flight.
REQ-026 count SHALL saturate by rule (REQ-019) and never wrap.
REQ-027 The non-granted port's ack, err and dout SHALL be unaffected by a transaction.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, count=0, all ack/err/dout/stk_din/stk_we/stk_oe=0, and busy=0.
REQ-029 stk_rst SHALL be 1 during reset and for the first clock after deassertion, then 0, clearing the stack RAM pointer.
REQ-030 Reset mid-transaction SHALL abort it with no ack issued.
REQ-031 After reset, round-robin priority SHALL start at port 0.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, the grant SHALL go to the port not served last; every completed transaction, erroring or not, SHALL update the last-served port.
REQ-033 Without ARB_ROUND_ROBIN_EN: port 0 SHALL always win simultaneous requests (fixed priority).

Verification
REQ-034 Reset, then port 0 pushes 0x5A -> stk_we pulse with stk_din=0x5A, req0_ack 3 cycles later, err=0, count=1.
REQ-035 Push 0x11 then 0x22; port 1 pops twice -> req1_dout=0x22 then 0x11, count=0.
REQ-036 Pop at count=0 -> req0_ack and req0_err next cycle, no stk_oe, count stays 0.
REQ-037 256 pushes then a 257th push -> err=1, no stk_we, count=256.
REQ-038 Both ports request continuously with ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1; without it -> port 0 is always granted.
REQ-039 Reset asserted during ISSUE of a pop -> outputs cleared immediately, no ack, stk_rst high through the first post-reset clock, count=0.
